// File: rtl/cbus_arbiter_pkg.sv
// Shared types for the cbus arbiter: FSM states, cbus request/response bundles.
// Bus structs are sized for the widest supported bus; narrower instances slice them.
package cbus_arbiter_pkg;

  localparam int CBUS_ADDR_W = 64;
  localparam int CBUS_DATA_W = 64;
  localparam int CBUS_STRB_W = CBUS_DATA_W / 8;

  // msize encoding: 0=1B, 1=2B, 2=4B, 3=8B
  localparam logic [2:0] MSIZE4 = 3'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic                   valid;
    logic                   is_write;
    logic [CBUS_ADDR_W-1:0] addr;
    logic [2:0]             size;
    logic [CBUS_STRB_W-1:0] strobe;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic                   ok;
    logic [CBUS_DATA_W-1:0] data;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Two-way round-robin select: grants dbus when it is the only requester or when it holds priority.
// prio = 1 means dbus wins a tie.
module cbus_arbiter_rr_pick (
  input  logic prio,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_d,
  output logic grant_any
);

  assign grant_any = i_valid | d_valid;
  assign grant_d   = d_valid & (~i_valid | prio);

endmodule

// File: rtl/cbus_arbiter.sv
// Shares one cbus port between ibus and dbus; grant is locked until cresp_ok.
// Define CBUS_ARB_PERF_EN to add cnt_igrant/cnt_dgrant/cnt_conflict debug counters.
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter bit RESET_PRIO_D = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  output logic                iresp_data_ok,
  output logic [31:0]         iresp_data,
  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_data,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,
  output logic                creq_valid,
  output logic                creq_is_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_ok,
  input  logic [DATA_W-1:0]   cresp_data
);

  arb_state_t state, state_n;
  cbus_req_t  req_q, req_n;
  cbus_resp_t resp;
  logic       prio, prio_n;
  logic       owner_d, owner_n;
  logic       owner_valid;
  logic       grant_d, grant_any;

  cbus_arbiter_rr_pick u_pick (
    .prio      (prio),
    .i_valid   (ireq_valid),
    .d_valid   (dreq_valid),
    .grant_d   (grant_d),
    .grant_any (grant_any)
  );

  assign resp        = '{ok: cresp_ok, data: CBUS_DATA_W'(cresp_data)};
  assign owner_valid = owner_d ? dreq_valid : ireq_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= RESET_PRIO_D;
      owner_d <= 1'b0;
      req_q   <= '0;
    end else begin
      state   <= state_n;
      prio    <= prio_n;
      owner_d <= owner_n;
      req_q   <= req_n;
    end
  end

  always_comb begin
    state_n       = state;
    prio_n        = prio;
    owner_n       = owner_d;
    req_n         = req_q;
    iresp_data_ok = 1'b0;
    dresp_data_ok = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          owner_n     = grant_d;
          state_n     = grant_d ? BUSY_D : BUSY_I;
          req_n.valid = 1'b1;
          if (grant_d) begin
            req_n.is_write = |dreq_strobe;
            req_n.addr     = CBUS_ADDR_W'(dreq_addr);
            req_n.size     = dreq_size;
            req_n.strobe   = CBUS_STRB_W'(dreq_strobe);
            req_n.data     = CBUS_DATA_W'(dreq_data);
          end else begin
            req_n.is_write = 1'b0;
            req_n.addr     = CBUS_ADDR_W'(ireq_addr);
            req_n.size     = MSIZE4;
            req_n.strobe   = '0;
            req_n.data     = '0;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (resp.ok) begin
          state_n       = IDLE;
          prio_n        = ~owner_d;
          req_n.valid   = 1'b0;
          // owner qualified by its own valid so a same-cycle drop still suppresses data_ok
          iresp_data_ok = (state == BUSY_I) && ireq_valid;
          dresp_data_ok = (state == BUSY_D) && dreq_valid;
        end else if (!owner_valid) begin
          state_n = RECOVER;
        end
      end
      RECOVER: begin
        if (resp.ok) begin
          state_n     = IDLE;
          prio_n      = ~owner_d;
          req_n.valid = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign creq_valid    = req_q.valid;
  assign creq_is_write = req_q.is_write;
  assign creq_addr     = req_q.addr[ADDR_W-1:0];
  assign creq_size     = req_q.size;
  assign creq_strobe   = req_q.strobe[DATA_W/8-1:0];
  assign creq_data     = req_q.data[DATA_W-1:0];

  assign iresp_data = iresp_data_ok ? (req_q.addr[2] ? resp.data[63:32] : resp.data[31:0]) : 32'h0;
  assign dresp_data = dresp_data_ok ? resp.data[DATA_W-1:0] : '0;

  cresp_in_idle: assert property (@(posedge clk) disable iff (reset) !(cresp_ok && state == IDLE));

`ifdef CBUS_ARB_PERF_EN
  logic [63:0] cnt_igrant, cnt_dgrant, cnt_conflict;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_igrant   <= '0;
      cnt_dgrant   <= '0;
      cnt_conflict <= '0;
    end else begin
      if (state == IDLE && grant_any && !grant_d) cnt_igrant <= cnt_igrant + 64'd1;
      if (state == IDLE && grant_d)               cnt_dgrant <= cnt_dgrant + 64'd1;
      // single downstream port: whenever both ask, one of them is waiting
      if (ireq_valid && dreq_valid)               cnt_conflict <= cnt_conflict + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cbus_arbiter.sv
// Self-checking bench for cbus_arbiter: vector table of solo transactions plus
// hand-written conflict, abandon and async-reset sequences, with a response scoreboard.
`timescale 1ns/1ps
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid, iresp_data_ok;
  logic [63:0] ireq_addr;
  logic [31:0] iresp_data;
  logic        dreq_valid, dresp_data_ok;
  logic [63:0] dreq_addr, dreq_data, dresp_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        creq_valid, creq_is_write;
  logic [63:0] creq_addr, creq_data;
  logic [2:0]  creq_size;
  logic [7:0]  creq_strobe;
  logic        cresp_ok = 1'b0;
  logic [63:0] cresp_data = '0;

  cbus_arbiter #(.ADDR_W(64), .DATA_W(64), .RESET_PRIO_D(1'b1)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_addr(creq_addr),
    .creq_size(creq_size), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .cresp_ok(cresp_ok), .cresp_data(cresp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int stall_cfg = 1;
  int run = 0;
  int lat_i, lat_d;

  logic [31:0] iq[$];
  logic [63:0] dq[$];

  typedef struct packed {
    logic        is_write;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [31:0] low_run;
  } grant_t;
  grant_t gq[$];

  typedef struct {
    logic        is_d;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    int          stall;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rdata_of(input logic [63:0] a);
    if (a == 64'h8000_0004) return 64'h1111_2222_3333_4444;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_0F0F};
  endfunction

  // downstream memory: answers stall_cfg cycles after creq_valid is first seen
  always @(posedge clk) begin
    #1;
    if (reset || !creq_valid) begin
      cresp_ok = 1'b0;
      run = 0;
    end else if (run == stall_cfg) begin
      cresp_ok = 1'b1;
      cresp_data = rdata_of(creq_addr);
      run = 0;
    end else begin
      cresp_ok = 1'b0;
      run++;
    end
  end

  // response scoreboard, grant log and creq stability monitor
  logic   prev_v = 1'b0;
  int     low_run = 0;
  grant_t held, cur;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (iresp_data_ok) begin
        if (iq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL i_spurious: iresp_data_ok=1 with no pending fetch, want 0");
        end else chk("iresp_data", iresp_data, iq.pop_front());
      end
      if (dresp_data_ok) begin
        if (dq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL d_spurious: dresp_data_ok=1 with no pending access, want 0");
        end else chk("dresp_data", dresp_data, dq.pop_front());
      end
      if (creq_valid) begin
        cur.is_write = creq_is_write; cur.addr = creq_addr; cur.size = creq_size;
        cur.strobe = creq_strobe; cur.data = creq_data; cur.low_run = low_run;
        if (!prev_v) begin
          gq.push_back(cur);
          held = cur;
        end else begin
          n_cmp++;
          if ({cur.is_write, cur.addr, cur.size, cur.strobe, cur.data} !==
              {held.is_write, held.addr, held.size, held.strobe, held.data}) begin
            n_bad++;
            $display("FAIL creq_stable: addr %h strobe %h, want addr %h strobe %h",
                     cur.addr, cur.strobe, held.addr, held.strobe);
          end
        end
        low_run = 0;
      end else low_run++;
      prev_v = creq_valid;
    end
  end

  task automatic do_i(input logic [63:0] addr, input int dly, output int lat);
    logic [63:0] r;
    repeat (dly) begin @(posedge clk); #1; end
    r = rdata_of(addr);
    ireq_addr = addr;
    ireq_valid = 1'b1;
    iq.push_back(addr[2] ? r[63:32] : r[31:0]);
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (iresp_data_ok) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL i_timeout: no iresp_data_ok for %h", addr);
      iq.delete();
    end
    @(posedge clk); #1;
    ireq_valid = 1'b0;
  endtask

  task automatic do_d(input logic [63:0] addr, input logic [2:0] size, input logic [7:0] strobe,
                      input logic [63:0] wdata, input int dly, output int lat);
    repeat (dly) begin @(posedge clk); #1; end
    dreq_addr = addr; dreq_size = size; dreq_strobe = strobe; dreq_data = wdata;
    dreq_valid = 1'b1;
    dq.push_back(rdata_of(addr));
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (dresp_data_ok) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL d_timeout: no dresp_data_ok for %h", addr);
      dq.delete();
    end
    @(posedge clk); #1;
    dreq_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ireq_valid = 1'b0;
    dreq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    gq.delete();
  endtask

  task automatic pop_grant(input string name, input logic [63:0] exp_addr, output grant_t g);
    n_cmp++;
    if (gq.size() == 0) begin
      n_bad++;
      g = '0;
      $display("FAIL %s: no grant seen, want addr %h", name, exp_addr);
    end else begin
      g = gq.pop_front();
      if (g.addr !== exp_addr) begin
        n_bad++;
        $display("FAIL %s: grant addr %h, want %h", name, g.addr, exp_addr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    grant_t g;
    ireq_valid = 1'b0; ireq_addr = '0;
    dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    reset = 1'b1;
    #1;
    chk("rst_creq_valid", creq_valid, 0);
    chk("rst_creq_is_write", creq_is_write, 0);
    chk("rst_creq_addr", creq_addr, 0);
    chk("rst_creq_size", creq_size, 0);
    chk("rst_creq_strobe", creq_strobe, 0);
    chk("rst_creq_data", creq_data, 0);
    chk("rst_iresp_ok", iresp_data_ok, 0);
    chk("rst_dresp_ok", dresp_data_ok, 0);
    chk("rst_iresp_data", iresp_data, 0);
    chk("rst_dresp_data", dresp_data, 0);
    chk("rst_state", dut.state, IDLE);
    chk("rst_prio", dut.prio, 1);
    do_reset();

    // solo transactions: {is_d, addr, size, strobe, wdata, stall}
    tbl[0] = '{1'b0, 64'h8000_0004, 3'd2, 8'h00, 64'h0, 1};
    tbl[1] = '{1'b0, 64'h8000_0010, 3'd2, 8'h00, 64'h0, 0};
    tbl[2] = '{1'b1, 64'h8000_1000, 3'd2, 8'h0F, 64'h0000_0000_DEAD_BEEF, 5};
    tbl[3] = '{1'b1, 64'h8000_2008, 3'd3, 8'h00, 64'h0, 2};
    tbl[4] = '{1'b1, 64'h8000_2010, 3'd3, 8'hFF, 64'h0123_4567_89AB_CDEF, 0};
    tbl[5] = '{1'b0, 64'h8000_003C, 3'd2, 8'h00, 64'h0, 3};
    foreach (tbl[n]) begin
      stall_cfg = tbl[n].stall;
      if (tbl[n].is_d) begin
        do_d(tbl[n].addr, tbl[n].size, tbl[n].strobe, tbl[n].wdata, 0, lat_d);
        chk("d_latency", lat_d, tbl[n].stall + 1);
      end else begin
        do_i(tbl[n].addr, 0, lat_i);
        chk("i_latency", lat_i, tbl[n].stall + 1);
      end
      pop_grant("vec_grant", tbl[n].addr, g);
      chk("vec_size", g.size, tbl[n].size);
      chk("vec_strobe", g.strobe, tbl[n].strobe);
      chk("vec_is_write", g.is_write, tbl[n].is_d && (tbl[n].strobe != 0));
      if (tbl[n].is_d) chk("vec_wdata", g.data, tbl[n].wdata);
    end

    // conflict right after reset: dbus first, one idle cycle, then ibus
    do_reset();
    stall_cfg = 1;
    fork
      do_d(64'h8000_3000, 3'd3, 8'h00, 64'h0, 0, lat_d);
      do_i(64'h8000_0100, 0, lat_i);
    join
    chk("conf1_lat_d", lat_d, 2);
    chk("conf1_lat_i", lat_i, 5);
    pop_grant("conf1_first", 64'h8000_3000, g);
    pop_grant("conf1_second", 64'h8000_0100, g);
    chk("conf1_idle_gap", g.low_run, 1);

    // prio toggled twice, so dbus wins again
    fork
      do_d(64'h8000_3008, 3'd3, 8'h00, 64'h0, 0, lat_d);
      do_i(64'h8000_0104, 0, lat_i);
    join
    pop_grant("conf2_first", 64'h8000_3008, g);
    pop_grant("conf2_second", 64'h8000_0104, g);

    // abandoned fetch: RECOVER, no iresp_data_ok, dbus served afterwards
    stall_cfg = 4;
    fork
      begin
        ireq_addr = 64'h8000_0200;
        ireq_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        ireq_valid = 1'b0;
        @(posedge clk); #1;
        chk("abandon_state", dut.state, RECOVER);
      end
      do_d(64'h8000_4000, 3'd3, 8'h00, 64'h0, 2, lat_d);
    join
    chk("abandon_lat_d", lat_d, 9);
    pop_grant("abandon_i", 64'h8000_0200, g);
    pop_grant("abandon_then_d", 64'h8000_4000, g);

    // async reset in the middle of a dbus transaction
    stall_cfg = 10;
    dreq_addr = 64'h8000_5000; dreq_size = 3'd3; dreq_strobe = 8'hFF; dreq_data = 64'h55;
    dreq_valid = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_creq_valid", creq_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_creq_valid", creq_valid, 0);
    chk("midrst_state", dut.state, IDLE);
    chk("midrst_dresp_ok", dresp_data_ok, 0);
    @(posedge clk); #1;
    dreq_valid = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_creq_valid", creq_valid, 0);

`ifdef CBUS_ARB_PERF_EN
    do_reset();
    stall_cfg = 1;
    for (int c = 0; c < 3; c++) begin
      fork
        do_d(64'h8000_6000, 3'd3, 8'h00, 64'h0, 0, lat_d);
        do_i(64'h8000_0300, 0, lat_i);
      join
    end
    do_i(64'h8000_0304, 0, lat_i);
    do_i(64'h8000_0308, 0, lat_i);
    chk("cnt_igrant", dut.cnt_igrant, 5);
    chk("cnt_dgrant", dut.cnt_dgrant, 3);
    chk("cnt_conflict", dut.cnt_conflict, 9);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
